// File: rtl/core_rf_pkg.sv
// Shared defaults, the busy-counter width and the write-port priority helper
// for the multi-port integer register file.
package core_rf_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_DEPTH      = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD         = 2;
  localparam int DEF_NUM_WR         = 1;
  localparam int MAX_WR             = 4;
  localparam int BUSY_CNT_WIDTH     = DEF_REG_ADDR_WIDTH + 1;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } wr_match_t;

  // Highest-index asserted bit wins, matching write-port collision priority.
  function automatic wr_match_t highest_match(input logic [MAX_WR-1:0] match);
    wr_match_t m;
    m = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (match[w]) begin
        m.hit = 1'b1;
        m.idx = 2'(w);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/core_regfile_mp_if.sv
// Operand-read, writeback and destination-issue signals of the register file.
interface core_regfile_mp_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 1
);
  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]     rd_data;
  logic [NUM_RD-1:0]                rd_busy;
  logic [NUM_WR-1:0]                we;
  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0]     wr_data;
  logic                             issue_valid;
  logic [REG_ADDR_WIDTH-1:0]        issue_addr;
  logic                             issue_ready;
  logic [REG_ADDR_WIDTH:0]          busy_cnt;

  modport master (
    output rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr,
    input  rd_data, rd_busy, issue_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr,
    output rd_data, rd_busy, issue_ready, busy_cnt
  );
endinterface

// File: rtl/core_rf_scoreboard.sv
// Per-register busy scoreboard: issue handshake, writeback clear and a
// registered population count of outstanding destinations.
module core_rf_scoreboard #(
  parameter int REG_DEPTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [REG_DEPTH-1:0]             wr_hit,
  input  logic                             issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]        issue_addr,
  output logic [NUM_RD-1:0]                rd_busy,
  output logic                             issue_ready,
  output logic [REG_ADDR_WIDTH:0]          busy_cnt
);
  localparam int CNT_W = REG_ADDR_WIDTH + 1;
  localparam bit ZERO  = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [REG_DEPTH-1:0] busy;
  logic [REG_DEPTH-1:0] busy_next;
  logic [CNT_W-1:0]     cnt_next;
  logic                 issue_in_range;
  logic                 issue_is_zero;

  assign issue_in_range = int'(issue_addr) < REG_DEPTH;
  assign issue_is_zero  = ZERO && (issue_addr == '0);

  // Out-of-range and hardwired-zero destinations are always accepted but never tracked.
  always_comb begin
    issue_ready = 1'b1;
    if (issue_in_range && !issue_is_zero)
      issue_ready = !busy[issue_addr] || (BYP && wr_hit[issue_addr]);
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [REG_ADDR_WIDTH-1:0] a;
      a = rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (int'(a) < REG_DEPTH && !(ZERO && a == '0))
        rd_busy[k] = busy[a] && !(BYP && wr_hit[a]);
    end
  end

  // Clear first, then set, so a new producer keeps ownership over a retiring one.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and start from a default so
    // every path assigns every output; anything less would infer a latch.
    busy_next = busy & ~wr_hit;
    if (issue_valid && issue_ready && issue_in_range && !issue_is_zero)
      busy_next[issue_addr] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < REG_DEPTH; i++)
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file: data array, write-port arbitration and
// same-cycle write-to-read bypass; busy tracking lives in core_rf_scoreboard.
module core_regfile_mp
  import core_rf_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_DEPTH      = DEF_REG_DEPTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_RD         = DEF_NUM_RD,
  parameter int NUM_WR         = DEF_NUM_WR,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input logic              clk,
  input logic              rst,
  core_regfile_mp_if.slave bus
);
  localparam int AW   = REG_ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam bit ZERO = (ZERO_REG != 0);
  localparam bit BYP  = (BYPASS != 0);

  logic [DW-1:0]        mem [REG_DEPTH];
  logic [NUM_WR-1:0]    wr_ok;
  logic [REG_DEPTH-1:0] wr_hit;
  logic [NUM_RD*DW-1:0] rd_data;

  // A write counts only if it lands on a real, writable register.
  always_comb begin
    wr_ok  = '0;
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      logic [AW-1:0] wa;
      wa       = bus.wr_addr[w*AW +: AW];
      wr_ok[w] = bus.we[w] && (int'(wa) < REG_DEPTH) && !(ZERO && wa == '0);
      if (wr_ok[w])
        wr_hit[wa] = 1'b1;
    end
  end

  // Ports are applied in ascending order so the highest index lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: architectural state must read 0 after reset, so the array is
      // built from resettable flops rather than left to power-up contents.
      for (int i = 0; i < REG_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_ok[w])
          mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DW +: DW];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]     a;
      logic [MAX_WR-1:0] match;
      wr_match_t         m;
      a     = bus.rd_addr[k*AW +: AW];
      match = '0;
      for (int w = 0; w < NUM_WR; w++)
        match[w] = wr_ok[w] && (bus.wr_addr[w*AW +: AW] == a);
      m = highest_match(match);
      if (int'(a) >= REG_DEPTH || (ZERO && a == '0))
        rd_data[k*DW +: DW] = '0;
      else if (BYP && m.hit)
        rd_data[k*DW +: DW] = bus.wr_data[int'(m.idx)*DW +: DW];
      else
        rd_data[k*DW +: DW] = mem[a];
    end
  end

  assign bus.rd_data = rd_data;

  core_rf_scoreboard #(
    .REG_DEPTH     (REG_DEPTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_RD        (NUM_RD),
    .ZERO_REG      (ZERO_REG),
    .BYPASS        (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (bus.rd_addr),
    .wr_hit     (wr_hit),
    .issue_valid(bus.issue_valid),
    .issue_addr (bus.issue_addr),
    .rd_busy    (bus.rd_busy),
    .issue_ready(bus.issue_ready),
    .busy_cnt   (bus.busy_cnt)
  );

endmodule

// File: tb/tb_core_regfile_mp.sv
// Self-checking bench for core_regfile_mp (2 read, 2 write ports): directed
// vector table, reset corner cases, then random traffic against a model.
module tb_core_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_regfile_mp_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  core_regfile_mp #(
    .DATA_WIDTH(32), .REG_DEPTH(32), .REG_ADDR_WIDTH(5),
    .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Current stimulus, mirrored locally for the reference model.
  logic [1:0]  s_we;
  logic [4:0]  s_wa [2];
  logic [31:0] s_wd [2];

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic iv, input logic [4:0] ia);
    s_we = we; s_wa[0] = wa0; s_wa[1] = wa1; s_wd[0] = wd0; s_wd[1] = wd1;
    bus.we          = we;
    bus.wr_addr     = {wa1, wa0};
    bus.wr_data     = {wd1, wd0};
    bus.rd_addr     = {ra1, ra0};
    bus.issue_valid = iv;
    bus.issue_addr  = ia;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ia;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_ready;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl [13];

  // Reference model: architectural registers and the set of pending destinations.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit m_write_to(input logic [4:0] a);
    for (int w = 0; w < 2; w++)
      if (s_we[w] && s_wa[w] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return 32'h0;
    r = m_regs[a];
    for (int w = 0; w < 2; w++)
      if (s_we[w] && s_wa[w] == a) r = s_wd[w];
    return r;
  endfunction

  function automatic bit m_rd_busy(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !m_write_to(a);
  endfunction

  function automatic bit m_ready(input logic [4:0] a);
    return (a == 0) || !m_busy[a] || m_write_to(a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply one edge to the model: retire writes, then accept an issue.
  task automatic m_edge(input logic iv, input logic [4:0] ia);
    bit rdy;
    rdy = m_ready(ia);
    for (int w = 0; w < 2; w++)
      if (s_we[w] && s_wa[w] != 0) begin
        m_regs[s_wa[w]] = s_wd[w];
        m_busy[s_wa[w]] = 1'b0;
      end
    if (iv && rdy && ia != 0) m_busy[ia] = 1'b1;
  endtask

  initial begin
    logic [4:0] ra0, ra1, ia;
    logic       iv;
    m_clear();

    // Reset state with preloaded-looking inputs.
    drive(2'b11, 5'd7, 32'hAAAA5555, 5'd8, 32'h12345678, 5'd7, 5'd8, 1'b0, 5'd5);
    repeat (2) @(posedge clk);
    #2;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0, 5'd5);
    #1;
    check("reset_rd0", bus.rd_data[31:0], 32'h0);
    check("reset_rd1", bus.rd_data[63:32], 32'h0);
    check("reset_cnt", bus.busy_cnt, 6'd0);
    check("reset_ready", bus.issue_ready, 1'b1);
    check("reset_busy", bus.rd_busy, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //               we     wa0   wd0           wa1   wd1    ra0   ra1   iv    ia    e_rd0         e_rd1         busy   rdy   cnt
    tbl[0]  = '{2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 6'd0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b1, 6'd0};
    tbl[2]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 2'b00, 1'b1, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0};
    tbl[4]  = '{2'b11, 5'd3, 32'h11,       5'd3, 32'h22, 5'd3, 5'd3, 1'b0, 5'd0, 32'h22,      32'h22,       2'b00, 1'b1, 6'd0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h22,       32'h22,       2'b00, 1'b1, 6'd0};
    tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h0,        32'h0,        2'b00, 1'b1, 6'd1};
    tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h0,        32'h0,        2'b11, 1'b0, 6'd1};
    tbl[8]  = '{2'b01, 5'd9, 32'h55,       5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd9, 32'h55,       32'h22,       2'b00, 1'b1, 6'd0};
    tbl[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd4, 5'd9, 1'b1, 5'd4, 32'h0,        32'h55,       2'b00, 1'b1, 6'd1};
    tbl[10] = '{2'b01, 5'd4, 32'h66,       5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4, 32'h66,       32'h66,       2'b00, 1'b1, 6'd1};
    tbl[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd4, 32'h66,       32'h0,        2'b01, 1'b0, 6'd1};
    tbl[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 5'd0, 5'd4, 1'b1, 5'd0, 32'h0,        32'h66,       2'b10, 1'b1, 6'd1};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
            tbl[i].ra0, tbl[i].ra1, tbl[i].iv, tbl[i].ia);
      #1;
      check($sformatf("vec%0d_rd0", i), bus.rd_data[31:0], tbl[i].e_rd0);
      check($sformatf("vec%0d_rd1", i), bus.rd_data[63:32], tbl[i].e_rd1);
      check($sformatf("vec%0d_busy", i), bus.rd_busy, tbl[i].e_busy);
      check($sformatf("vec%0d_ready", i), bus.issue_ready, tbl[i].e_ready);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt", i), bus.busy_cnt, tbl[i].e_cnt);
    end

    // x4 is still busy; add x10 and x11 for three outstanding destinations.
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b1, 5'd10);
    @(posedge clk); #1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b1, 5'd11);
    @(posedge clk); #1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b0, 5'd0);
    #1;
    check("pre_rst_cnt", bus.busy_cnt, 6'd3);
    check("pre_rst_busy", bus.rd_busy, 2'b11);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_cnt", bus.busy_cnt, 6'd0);
    check("mid_rst_busy", bus.rd_busy, 2'b00);
    bus.rd_addr = {5'd4, 5'd7};
    #1;
    check("mid_rst_rd0", bus.rd_data[31:0], 32'h0);
    check("mid_rst_rd1", bus.rd_data[63:32], 32'h0);
    rst = 1'b0;
    m_clear();
    @(posedge clk); #1;

    // Random traffic over a small address window to force collisions.
    for (int c = 0; c < 400; c++) begin
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ia  = 5'($urandom_range(0, 7));
      iv  = 1'($urandom_range(0, 1));
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom, ra0, ra1, iv, ia);
      #1;
      check("rnd_rd0", bus.rd_data[31:0], m_read(ra0));
      check("rnd_rd1", bus.rd_data[63:32], m_read(ra1));
      check("rnd_busy", bus.rd_busy, {m_rd_busy(ra1), m_rd_busy(ra0)});
      check("rnd_ready", bus.issue_ready, m_ready(ia));
      m_edge(iv, ia);
      @(posedge clk);
      #1;
      check("rnd_cnt", bus.busy_cnt, 64'(m_count()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_regfile_mp.md
# core_regfile_mp

Parametrised multi-port integer register file for the pipelined RV32I core. It adds N read ports, M write ports, an optional hardwired zero register, write-to-read bypass, and a per-register busy scoreboard with an issue handshake. It sits between decode/issue, which reads operands and allocates destinations, and writeback, which retires results.

## Interface
Parameters:
- DATA_WIDTH, 32, register width
- REG_DEPTH, 32, number of registers
- REG_ADDR_WIDTH, 5, address width; REG_DEPTH ≤ 2^REG_ADDR_WIDTH
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports (1..4)
- ZERO_REG, 1, register 0 reads 0, ignores writes, never busy
- BYPASS, 1, same-cycle write data forwarded to reads

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*REG_ADDR_WIDTH  read addresses, port k at slice k
- rd_data  out  NUM_RD*DATA_WIDTH  read data, combinational
- rd_busy  out  NUM_RD  addressed register has a pending writeback
- we  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*REG_ADDR_WIDTH  write addresses
- wr_data  in  NUM_WR*DATA_WIDTH  write data
- issue_valid  in  1  request to allocate issue_addr as a destination
- issue_addr  in  REG_ADDR_WIDTH  destination to mark busy
- issue_ready  out  1  allocation accepted this cycle
- busy_cnt  out  REG_ADDR_WIDTH+1  number of busy registers

## Operation
- Storage: REG_DEPTH×DATA_WIDTH array, plus a REG_DEPTH-bit busy vector.
- Reset (rst=1, asynchronous): all registers become 0, busy becomes 0, busy_cnt becomes 0. rd_data then reads 0, rd_busy 0, and issue_ready equals !busy of the addressed register, which is 1.
- Write: for each port w with we[w]=1, the addressed register takes wr_data[w] on the edge. If several ports hit the same address, the highest port index wins. With ZERO_REG=1, writes to address 0 are dropped.
- Writeback clears busy: any enabled write to address a clears busy[a] on the edge.
- Read, per port k:
  - ZERO_REG=1 and address 0: data 0.
  - Otherwise, BYPASS=1 and any enabled write matches the address: data is wr_data of the highest matching port.
  - Otherwise: the array value.
- rd_busy[k] = busy[addr]. With BYPASS=1, rd_busy[k] is 0 if a write to that address is enabled this cycle. It is always 0 for address 0 when ZERO_REG=1.
- Issue handshake:
  - issue_ready = !busy[issue_addr], or 1 when BYPASS=1 and a write to issue_addr is enabled this cycle.
  - issue_valid && issue_ready: busy[issue_addr] is set on the edge.
  - Set wins over a simultaneous clear to the same register (the new producer owns it).
  - issue_valid && !issue_ready: no state change; the requester must hold the request.
  - With ZERO_REG=1, issue to address 0 is always ready and sets nothing.
- Addresses ≥ REG_DEPTH: reads return 0 and report not busy; writes and issues are ignored.
- busy_cnt is registered and equals popcount(busy) after each edge.
  - It updates as +1 on an accepted set and −1 for each distinct cleared register.
  - It never exceeds REG_DEPTH.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, we, wr_addr, wr_data).
- Write visible in the array 1 cycle after the edge; visible the same cycle via bypass when BYPASS=1.
- A busy set is visible on rd_busy and issue_ready the cycle after acceptance.
- issue_ready is combinational from issue_addr, busy, and the write ports; it has no combinational dependence on issue_valid.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves normally.

## Structure
- Package core_rf_pkg:
  - default widths and depths;
  - localparam for the busy counter width;
  - function for the highest-index write match.
- Sub-module core_rf_scoreboard holds the busy vector, issue handshake and busy_cnt. The top module holds the data array, write arbitration and bypass muxes.
- Port arrays are flattened; slice k is [k*W +: W].

## Test plan
- Reset: with rst=1, preload is irrelevant. All rd_data read 0, busy_cnt=0, and issue_ready=1 for issue_addr=5.
- Write/read: write 0xDEADBEEF to x7 through port 0. The next cycle rd_addr0=7 returns 0xDEADBEEF. Writing x0=0x1234 still reads 0.
- Bypass and collision (NUM_WR=2, BYPASS=1): port0 writes x3=0x11 and port1 writes x3=0x22 in the same cycle. Both reads of x3 return 0x22 that cycle and after the edge.
- Scoreboard:
  - Issue x9: the next cycle rd_busy=1, busy_cnt=1, and issue_ready for x9 is 0.
  - Write x9: rd_busy drops the same cycle (BYPASS=1). busy_cnt=0 after the edge.
- Simultaneous set/clear: x4 is busy; a writeback to x4 and an issue of x4 occur in the same cycle. After the edge x4 stays busy and busy_cnt is unchanged.
- Reset mid-operation: with 3 registers busy, pulse rst between edges. busy_cnt=0 and all rd_busy=0 immediately, without waiting for a clock edge.
